// File: rtl/traffic_pkg.sv
// ---------------------------------------------------------------------------
// traffic_pkg
// Definitions shared by the traffic light controller and its upstream
// request latch: the 7-bit light codes, the lane index constants, the
// decoded-light enum and a helper that maps a raw code onto that enum.
// ---------------------------------------------------------------------------
package traffic_pkg;

  // Raw light codes driven by the controller
  localparam logic [6:0] LIGHT_GREEN  = 7'b0010000;
  localparam logic [6:0] LIGHT_YELLOW = 7'b0010001;
  localparam logic [6:0] LIGHT_RED    = 7'b0101111;

  // Lane indices, shared bit order for detectors, requests and lights
  localparam int LANE_W    = 0;
  localparam int LANE_EL   = 1;
  localparam int LANE_NL   = 2;
  localparam int LANE_E    = 3;
  localparam int NUM_LANES = 4;

  typedef enum logic [1:0] {
    GREEN   = 2'd0,
    YELLOW  = 2'd1,
    RED     = 2'd2,
    INVALID = 2'd3
  } light_t;

  // Anything that is not exactly one of the three legal codes is INVALID.
  function automatic light_t decode_light(input logic [6:0] code);
    light_t result;
    case (code)
      LIGHT_GREEN:  result = GREEN;
      LIGHT_YELLOW: result = YELLOW;
      LIGHT_RED:    result = RED;
      default:      result = INVALID;
    endcase
    return result;
  endfunction

endpackage

// File: rtl/light_code_decode.sv
// ---------------------------------------------------------------------------
// light_code_decode
// Purely combinational decode of one 7-bit light code into the 2-bit
// light_t enum (GREEN / YELLOW / RED / INVALID).
//
// Ports:
//   code   in  7  raw light code from the controller
//   light  out 2  decoded light
// ---------------------------------------------------------------------------
module light_code_decode
  import traffic_pkg::*;
(
  input  logic [6:0] code,
  output light_t     light
);

  always_comb begin
    light = decode_light(code);
  end

endmodule

// File: rtl/vehicle_request_latch.sv
// ---------------------------------------------------------------------------
// vehicle_request_latch
// Debounces the four raw vehicle detectors and latches each one as a request
// that is held until the corresponding approach shows green. Also keeps a
// per-lane wait counter with a starvation flag, reports the largest wait,
// and latches a sticky fault on illegal or conflicting light codes.
//
// Optional build macro DET_SYNC_EN: when defined, Det passes through a
// two-flop synchronizer before debounce (request latency grows by 2 edges).
//
// Ports:
//   Clock    in  1       system clock, rising edge
//   Resetn   in  1       asynchronous active-low reset
//   Det      in  4       raw detectors (bit0 W, bit1 EL, bit2 NL, bit3 E)
//   WTL      in  7       W light code
//   ELTL     in  7       EL light code
//   NTL      in  7       NL light code
//   ETL      in  7       E light code
//   Req      out 4       latched requests, same bit order as Det
//   Starve   out 4       per-lane wait >= STARVE_LIM
//   WaitMax  out WAIT_W  largest of the four wait counters
//   Fault    out 1       sticky illegal / conflicting light code
// ---------------------------------------------------------------------------
module vehicle_request_latch
  import traffic_pkg::*;
#(
  parameter int unsigned DEB_CYCLES = 4,
  parameter int unsigned WAIT_W     = 8,
  parameter int unsigned STARVE_LIM = 200
) (
  input  logic              Clock,
  input  logic              Resetn,
  input  logic [3:0]        Det,
  input  logic [6:0]        WTL,
  input  logic [6:0]        ELTL,
  input  logic [6:0]        NTL,
  input  logic [6:0]        ETL,
  output logic [3:0]        Req,
  output logic [3:0]        Starve,
  output logic [WAIT_W-1:0] WaitMax,
  output logic              Fault
);

  localparam logic [3:0]        DEB_MAX    = 4'(DEB_CYCLES);
  localparam logic [WAIT_W-1:0] WAIT_SAT   = '1;
  localparam logic [WAIT_W-1:0] STARVE_THR = WAIT_W'(STARVE_LIM);

  // -------------------------------------------------------------------------
  // Light decode
  // -------------------------------------------------------------------------
  logic [6:0]        code_arr  [NUM_LANES];
  light_t            light_arr [NUM_LANES];
  logic [3:0]        green;
  logic [3:0]        invalid;

  assign code_arr[LANE_W]  = WTL;
  assign code_arr[LANE_EL] = ELTL;
  assign code_arr[LANE_NL] = NTL;
  assign code_arr[LANE_E]  = ETL;

  for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_decode
    light_code_decode u_decode (
      .code  (code_arr[gi]),
      .light (light_arr[gi])
    );
    assign green[gi]   = (light_arr[gi] == GREEN);
    assign invalid[gi] = (light_arr[gi] == INVALID);
  end

  // -------------------------------------------------------------------------
  // Optional detector synchronizer
  // -------------------------------------------------------------------------
  logic [3:0] det_deb;

`ifdef DET_SYNC_EN
  logic [3:0] det_meta_reg;
  logic [3:0] det_sync_reg;

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      det_meta_reg <= '0;
      det_sync_reg <= '0;
    end else begin
      det_meta_reg <= Det;
      det_sync_reg <= det_meta_reg;
    end
  end

  assign det_deb = det_sync_reg;
`else
  assign det_deb = Det;
`endif

  // -------------------------------------------------------------------------
  // Per-lane debounce, request latch and wait counter
  // -------------------------------------------------------------------------
  logic [WAIT_W-1:0] wait_arr [NUM_LANES];
  logic [3:0]        req_vec;
  logic [3:0]        starve_vec;

  for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
    logic [3:0]        deb_cnt_reg;
    logic [3:0]        deb_cnt_next;
    logic              req_reg;
    logic              req_next;
    logic [WAIT_W-1:0] wait_reg;
    logic [WAIT_W-1:0] wait_next;
    logic              starve_reg;
    logic              starve_next;
    logic              present;

    // present is taken from the registered count, so Req rises one edge
    // after the count reaches DEB_CYCLES.
    assign present = (deb_cnt_reg == DEB_MAX);

    always_comb begin
      deb_cnt_next = deb_cnt_reg;
      req_next     = req_reg;
      wait_next    = wait_reg;

      // Any low sample restarts the run; saturate once present.
      if (!det_deb[gi]) begin
        deb_cnt_next = '0;
      end else if (deb_cnt_reg != DEB_MAX) begin
        deb_cnt_next = deb_cnt_reg + 4'd1;
      end

      // Green service clears the request even if a vehicle arrives on the
      // same edge; a vehicle still present re-requests once green ends.
      if (green[gi]) begin
        req_next  = 1'b0;
        wait_next = '0;
      end else begin
        if (present) begin
          req_next = 1'b1;
        end
        if (req_reg && (wait_reg != WAIT_SAT)) begin
          wait_next = wait_reg + 1'b1;
        end
      end

      // Computed from the next count so the flag lines up with the counter.
      starve_next = (wait_next >= STARVE_THR);
    end

    always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
        deb_cnt_reg <= '0;
        req_reg     <= 1'b0;
        wait_reg    <= '0;
        starve_reg  <= 1'b0;
      end else begin
        deb_cnt_reg <= deb_cnt_next;
        req_reg     <= req_next;
        wait_reg    <= wait_next;
        starve_reg  <= starve_next;
      end
    end

    assign req_vec[gi]    = req_reg;
    assign starve_vec[gi] = starve_reg;
    assign wait_arr[gi]   = wait_reg;
  end

  assign Req    = req_vec;
  assign Starve = starve_vec;

  // -------------------------------------------------------------------------
  // Largest wait across the lanes (combinational over registered counters)
  // -------------------------------------------------------------------------
  logic [WAIT_W-1:0] wait_max;

  always_comb begin
    wait_max = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (wait_arr[i] > wait_max) begin
        wait_max = wait_arr[i];
      end
    end
  end

  assign WaitMax = wait_max;

  // -------------------------------------------------------------------------
  // Sticky fault
  // Legal green sets are {EL}, {E,W}, {E,NL}, {E} and {}: EL must be green
  // alone, and W / NL must never be green together.
  // -------------------------------------------------------------------------
  logic conflict;
  logic fault_reg;
  logic fault_next;

  assign conflict = (green[LANE_EL] &
                     (green[LANE_W] | green[LANE_NL] | green[LANE_E])) |
                    (green[LANE_W] & green[LANE_NL]);

  assign fault_next = fault_reg | (|invalid) | conflict;

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      fault_reg <= 1'b0;
    end else begin
      fault_reg <= fault_next;
    end
  end

  assign Fault = fault_reg;

endmodule

// File: tb/tb_vehicle_request_latch.sv
// ---------------------------------------------------------------------------
// tb_vehicle_request_latch
// Self-checking bench: table-driven vectors, hand-written sequences for the
// multi-cycle corners, and a randomized run against a behavioural model.
// ---------------------------------------------------------------------------
module tb_vehicle_request_latch;

  localparam int DEB  = 4;
  localparam int LIM  = 200;
  localparam int WMAX = 255;
`ifdef DET_SYNC_EN
  localparam int SYNC = 2;
`else
  localparam int SYNC = 0;
`endif
  // Edge number (counting from the first high sample) on which Req rises
  localparam int LAT = DEB + 1 + SYNC;

  localparam logic [6:0] G = 7'b0010000;
  localparam logic [6:0] Y = 7'b0010001;
  localparam logic [6:0] R = 7'b0101111;

  logic       Clock  = 1'b0;
  logic       Resetn = 1'b0;
  logic [3:0] Det    = 4'd0;
  logic [6:0] WTL    = R;
  logic [6:0] ELTL   = R;
  logic [6:0] NTL    = R;
  logic [6:0] ETL    = R;
  logic [3:0] Req;
  logic [3:0] Starve;
  logic [7:0] WaitMax;
  logic       Fault;

  vehicle_request_latch dut (
    .Clock   (Clock),
    .Resetn  (Resetn),
    .Det     (Det),
    .WTL     (WTL),
    .ELTL    (ELTL),
    .NTL     (NTL),
    .ETL     (ETL),
    .Req     (Req),
    .Starve  (Starve),
    .WaitMax (WaitMax),
    .Fault   (Fault)
  );

  always #5 Clock = ~Clock;

  int checks = 0;
  int errors = 0;

  // ---------------- behavioural model ----------------
  int         m_run  [4];   // length of the current run of high samples
  int         m_req  [4];
  int         m_wait [4];
  int         m_fault;
  logic [3:0] m_dh1, m_dh2; // detector history for the synchronizer delay

  task automatic model_reset();
    for (int l = 0; l < 4; l++) begin
      m_run[l] = 0; m_req[l] = 0; m_wait[l] = 0;
    end
    m_fault = 0; m_dh1 = 4'd0; m_dh2 = 4'd0;
  endtask

  task automatic model_edge();
    logic [6:0] codes [4];
    int g [4];
    int bad;
    logic [3:0] deb_in;
    codes[0] = WTL; codes[1] = ELTL; codes[2] = NTL; codes[3] = ETL;
    bad = 0;
    for (int l = 0; l < 4; l++) begin
      g[l] = (codes[l] == G) ? 1 : 0;
      if (codes[l] != G && codes[l] != Y && codes[l] != R) bad = 1;
    end
    if (g[1] == 1 && (g[0] + g[2] + g[3]) > 0) bad = 1;
    if (g[0] == 1 && g[2] == 1) bad = 1;
    if (bad != 0) m_fault = 1;
    deb_in = (SYNC != 0) ? m_dh2 : Det;
    for (int l = 0; l < 4; l++) begin
      if (g[l] != 0) begin
        m_req[l]  = 0;
        m_wait[l] = 0;
      end else begin
        if (m_req[l] != 0 && m_wait[l] < WMAX) m_wait[l] = m_wait[l] + 1;
        if (m_run[l] >= DEB) m_req[l] = 1;
      end
      m_run[l] = deb_in[l] ? ((m_run[l] < 1000) ? m_run[l] + 1 : 1000) : 0;
    end
    m_dh2 = m_dh1;
    m_dh1 = Det;
  endtask

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic compare_model();
    int er, es, em;
    er = 0; es = 0; em = 0;
    for (int l = 0; l < 4; l++) begin
      if (m_req[l] != 0) er |= (1 << l);
      if (m_wait[l] >= LIM) es |= (1 << l);
      if (m_wait[l] > em) em = m_wait[l];
    end
    check("model_req", int'(Req), er);
    check("model_starve", int'(Starve), es);
    check("model_waitmax", int'(WaitMax), em);
    check("model_fault", int'(Fault), m_fault);
  endtask

  // One clock edge: model follows the inputs present at the edge, outputs
  // are sampled 1 ns later.
  task automatic tick();
    @(posedge Clock);
    model_edge();
    #1;
    compare_model();
  endtask

  task automatic do_reset();
    Resetn = 1'b0;
    Det = 4'd0; WTL = R; ELTL = R; NTL = R; ETL = R;
    model_reset();
    #1;
    check("reset_req", int'(Req), 0);
    check("reset_starve", int'(Starve), 0);
    check("reset_waitmax", int'(WaitMax), 0);
    check("reset_fault", int'(Fault), 0);
    @(posedge Clock);
    #1;
    Resetn = 1'b1;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    bit         rst_before;
    logic [3:0] det;
    logic [6:0] w, el, nl, e;
    logic [3:0] exp_req;
    logic       exp_fault;
  } vec_t;

  localparam int NVEC = 19;
  vec_t tbl [NVEC];

  task automatic set_vec(input int i, input bit rb, input logic [3:0] d,
                         input logic [6:0] w, input logic [6:0] el,
                         input logic [6:0] nl, input logic [6:0] e,
                         input logic [3:0] er, input logic ef);
    tbl[i].rst_before = rb; tbl[i].det = d;
    tbl[i].w = w; tbl[i].el = el; tbl[i].nl = nl; tbl[i].e = e;
    tbl[i].exp_req = er; tbl[i].exp_fault = ef;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int pat [8];
    int e;

    // Scenario 1 as a table: Det[0] high from edge 1, all lights red
    for (int i = 0; i < 10; i++) begin
      set_vec(i, (i == 0), 4'b0001, R, R, R, R,
              ((i + 1) >= LAT) ? 4'b0001 : 4'b0000, 1'b0);
    end
    // Legal green sets and yellows leave Fault clear; W+NL green sets it
    set_vec(10, 1, 4'b0000, R, G, R, R, 4'b0000, 1'b0);
    set_vec(11, 0, 4'b0000, G, R, R, G, 4'b0000, 1'b0);
    set_vec(12, 0, 4'b0000, R, R, G, G, 4'b0000, 1'b0);
    set_vec(13, 0, 4'b0000, R, R, R, G, 4'b0000, 1'b0);
    set_vec(14, 0, 4'b0000, Y, Y, Y, Y, 4'b0000, 1'b0);
    set_vec(15, 0, 4'b0000, R, R, R, R, 4'b0000, 1'b0);
    set_vec(16, 0, 4'b0000, G, R, G, R, 4'b0000, 1'b1);
    set_vec(17, 0, 4'b0000, R, R, R, R, 4'b0000, 1'b1);
    set_vec(18, 0, 4'b0000, R, G, R, R, 4'b0000, 1'b1);

    for (int i = 0; i < NVEC; i++) begin
      if (tbl[i].rst_before) do_reset();
      Det = tbl[i].det; WTL = tbl[i].w; ELTL = tbl[i].el;
      NTL = tbl[i].nl; ETL = tbl[i].e;
      tick();
      check("tbl_req", int'(Req), int'(tbl[i].exp_req));
      check("tbl_fault", int'(Fault), int'(tbl[i].exp_fault));
      $display("vec %0d det=%b req=%b fault=%0d", i, Det, Req, Fault);
    end

    // Scenario 2: Det[2] = 1,1,1,0,1,1,1,1 then held high
    do_reset();
    pat = '{1, 1, 1, 0, 1, 1, 1, 1};
    for (e = 1; e <= 4 + LAT; e++) begin
      Det = (e <= 8 && pat[e-1] == 0) ? 4'b0000 : 4'b0100;
      tick();
      if (e == 4 + LAT - 1) check("glitch_no_req", int'(Req[2]), 0);
      if (e == 4 + LAT)     check("glitch_req", int'(Req[2]), 1);
    end
    $display("glitch sequence req=%b", Req);

    // Scenario 3: served by one green cycle, vehicle still present
    do_reset();
    Det = 4'b0010;
    repeat (LAT) tick();
    check("el_req", int'(Req[1]), 1);
    repeat (3) tick();
    check("el_wait3", int'(WaitMax), 3);
    ELTL = G;
    tick();
    check("el_cleared", int'(Req[1]), 0);
    check("el_wait_cleared", int'(WaitMax), 0);
    ELTL = R;
    tick();
    check("el_rerequest", int'(Req[1]), 1);
    $display("el service req=%b waitmax=%0d", Req, WaitMax);

    // Scenario 4: starvation threshold and saturation on lane E
    do_reset();
    Det = 4'b1000;
    repeat (LAT) tick();
    Det = 4'b0000;
    check("e_req", int'(Req[3]), 1);
    repeat (LIM - 1) tick();
    check("e_starve_below", int'(Starve[3]), 0);
    check("e_wait_below", int'(WaitMax), LIM - 1);
    tick();
    check("e_starve_at", int'(Starve[3]), 1);
    check("e_wait_at", int'(WaitMax), LIM);
    repeat (WMAX - LIM) tick();
    check("e_wait_sat", int'(WaitMax), WMAX);
    repeat (5) tick();
    check("e_wait_hold", int'(WaitMax), WMAX);
    check("e_req_hold", int'(Req[3]), 1);
    $display("starve sequence starve=%b waitmax=%0d", Starve, WaitMax);

    // Scenario 5: EL+W conflict, sticky fault, asynchronous mid-cycle reset
    do_reset();
    Det = 4'b0001;
    repeat (LAT) tick();
    check("conf_req", int'(Req[0]), 1);
    ELTL = G; WTL = G;
    tick();
    check("conf_fault", int'(Fault), 1);
    ELTL = R; WTL = R;
    repeat (3) tick();
    check("conf_sticky", int'(Fault), 1);
    check("conf_rereq", int'(Req[0]), 1);
    #2;
    Resetn = 1'b0;
    #1;
    check("async_req", int'(Req), 0);
    check("async_fault", int'(Fault), 0);
    check("async_waitmax", int'(WaitMax), 0);
    model_reset();
    Det = 4'b0000;
    @(posedge Clock);
    #1;
    Resetn = 1'b1;
    $display("async reset req=%b fault=%0d", Req, Fault);

    // Scenario 6: invalid code for one cycle
    do_reset();
    NTL = 7'b1111111;
    tick();
    check("invalid_fault", int'(Fault), 1);
    NTL = R;
    tick();
    check("invalid_sticky", int'(Fault), 1);
    $display("invalid code fault=%0d", Fault);

    // Randomized run against the model
    for (int blk = 0; blk < 5; blk++) begin
      int gset;
      do_reset();
      gset = 4;
      for (int c = 0; c < 300; c++) begin
        logic [6:0] codes [4];
        for (int l = 0; l < 4; l++) begin
          if ($urandom_range(0, 3) == 0) Det[l] = ~Det[l];
          codes[l] = ($urandom_range(0, 1) == 0) ? R : Y;
        end
        if ($urandom_range(0, 7) == 0) gset = $urandom_range(0, 4);
        case (gset)
          0: codes[1] = G;
          1: begin codes[3] = G; codes[0] = G; end
          2: begin codes[3] = G; codes[2] = G; end
          3: codes[3] = G;
          default: ;
        endcase
        if ($urandom_range(0, 99) == 0)
          codes[$urandom_range(0, 3)] = 7'($urandom_range(0, 127));
        WTL = codes[0]; ELTL = codes[1]; NTL = codes[2]; ETL = codes[3];
        tick();
      end
      $display("random block %0d req=%b starve=%b waitmax=%0d fault=%0d",
               blk, Req, Starve, WaitMax, Fault);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
